cpu_run_controller: RTL and testbench

//   Sequences the CPU core: generates its power-on reset, converts the raw

---
 rtl/cpu_run_controller.sv | 171 +++++++++++++++++
 tb/tb_cpu_run_controller.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : cpu_run_controller
// Purpose  : Run/halt sequencer for the CPU core. Generates the power-on
//            reset hold, debounces the board run/halt switch into toggle
//            pulses, supports single-step and a PC breakpoint, and counts
//            executed (enabled) cycles with saturation.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_run_controller #(
  parameter int PC_WIDTH        = 8,
  parameter int COUNT_WIDTH     = 32,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RESET_CYCLES    = 8
) (
  input  logic                   clock,
  input  logic                   isReset,
  input  logic                   switch,
  input  logic                   stepRequest,
  input  logic                   breakEnable,
  input  logic [PC_WIDTH-1:0]    breakAddress,
  input  logic [PC_WIDTH-1:0]    pc,
  input  logic                   cpuHalted,
  output logic                   cpuReset,
  output logic                   cpuEnable,
  output logic [1:0]             runState,
  output logic [COUNT_WIDTH-1:0] cycleCount
);

  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES + 1) : 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);

  typedef enum logic [1:0] {
    RESET_HOLD = 2'd0,
    HALTED     = 2'd1,
    RUNNING    = 2'd2,
    STEP       = 2'd3
  } run_state_t;

  run_state_t              state;
  run_state_t              state_next;

  logic                    sync_meta;
  logic                    sync_q;
  logic                    stable_level;
  logic [DB_W-1:0]         db_count;
  logic                    toggle;

  logic [HOLD_W-1:0]       hold_count;
  logic                    resume;
  logic                    break_hit;
  logic [COUNT_WIDTH-1:0]  cycle_count;

  // Two-flop synchronizer for the asynchronous board switch.
  always_ff @(posedge clock) begin
    if (isReset) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= switch;
      sync_q    <= sync_meta;
    end
  end

  // Debounce: a change must persist DEBOUNCE_CYCLES cycles; either edge
  // produces a one-cycle toggle pulse when the stable level flips.
  always_ff @(posedge clock) begin
    if (isReset) begin
      db_count     <= '0;
      stable_level <= 1'b0;
      toggle       <= 1'b0;
    end else begin
      toggle <= 1'b0;
      if (sync_q != stable_level) begin
        if (db_count == DB_LAST) begin
          stable_level <= sync_q;
          db_count     <= '0;
          toggle       <= 1'b1;
        end else begin
          db_count <= db_count + DB_W'(1);
        end
      end else begin
        db_count <= '0;
      end
    end
  end

  // Reset-hold counter: counts released cycles spent in RESET_HOLD.
  always_ff @(posedge clock) begin
    if (isReset) begin
      hold_count <= '0;
    end else if (state == RESET_HOLD && hold_count != HOLD_LAST) begin
      hold_count <= hold_count + HOLD_W'(1);
    end
  end

  // Resume flag masks the breakpoint for the first RUNNING cycle so a
  // restart at the breakpoint PC executes that instruction.
  always_ff @(posedge clock) begin
    if (isReset) begin
      resume <= 1'b0;
    end else if (state == HALTED && toggle) begin
      resume <= 1'b1;
    end else if (state == RUNNING) begin
      resume <= 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (isReset) begin
      state <= RESET_HOLD;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and core-control outputs decoded from the current state.
  always_comb begin
    state_next = state;
    cpuReset   = 1'b0;
    cpuEnable  = 1'b0;
    break_hit  = 1'b0;
    case (state)
      RESET_HOLD: begin
        cpuReset = 1'b1;
        if (hold_count == HOLD_LAST) begin
          state_next = HALTED;
        end
      end
      HALTED: begin
        if (toggle) begin
          state_next = RUNNING;
        end else if (stepRequest) begin
          state_next = STEP;
        end
      end
      RUNNING: begin
        break_hit = breakEnable && (pc == breakAddress) && !resume;
        cpuEnable = !cpuHalted && !break_hit;
        if (cpuHalted || break_hit || toggle) begin
          state_next = HALTED;
        end
      end
      STEP: begin
        cpuEnable  = !cpuHalted;
        state_next = HALTED;
      end
      default: begin
        state_next = RESET_HOLD;
      end
    endcase
  end

  // Executed-cycle counter, saturating at all-ones.
  always_ff @(posedge clock) begin
    if (isReset) begin
      cycle_count <= '0;
    end else if (cpuEnable && !(&cycle_count)) begin
      cycle_count <= cycle_count + COUNT_WIDTH'(1);
    end
  end

  assign runState   = state;
  assign cycleCount = cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_run_controller
// Purpose  : Directed self-checking bench for cpu_run_controller with
//            DEBOUNCE_CYCLES=4, RESET_CYCLES=3, PC_WIDTH=8, COUNT_WIDTH=4.
//            Inputs change and outputs are sampled on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_run_controller;

  logic       clock;
  logic       isReset;
  logic       switch;
  logic       stepRequest;
  logic       breakEnable;
  logic [7:0] breakAddress;
  logic [7:0] pc;
  logic       cpuHalted;
  logic       cpuReset;
  logic       cpuEnable;
  logic [1:0] runState;
  logic [3:0] cycleCount;

  int vectors;
  int miscompares;

  cpu_run_controller #(
    .PC_WIDTH        (8),
    .COUNT_WIDTH     (4),
    .DEBOUNCE_CYCLES (4),
    .RESET_CYCLES    (3)
  ) dut (
    .clock        (clock),
    .isReset      (isReset),
    .switch       (switch),
    .stepRequest  (stepRequest),
    .breakEnable  (breakEnable),
    .breakAddress (breakAddress),
    .pc           (pc),
    .cpuHalted    (cpuHalted),
    .cpuReset     (cpuReset),
    .cpuEnable    (cpuEnable),
    .runState     (runState),
    .cycleCount   (cycleCount)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Directed sequence; times in comments are the falling edge reached.
  initial begin
    vectors      = 0;
    miscompares  = 0;
    isReset      = 1'b1;
    switch       = 1'b0;
    stepRequest  = 1'b0;
    breakEnable  = 1'b0;
    breakAddress = 8'h00;
    pc           = 8'h00;
    cpuHalted    = 1'b0;

    // t=10: one reset edge applied
    tick(1);
    check("rst_state",   32'(runState),   32'd0);
    check("rst_cpureset",32'(cpuReset),   32'd1);
    check("rst_enable",  32'(cpuEnable),  32'd0);
    check("rst_count",   32'(cycleCount), 32'd0);
    isReset = 1'b0;

    // hold for 3 cycles after release
    tick(1);
    check("hold1_cpureset", 32'(cpuReset), 32'd1);
    tick(1);
    check("hold2_cpureset", 32'(cpuReset), 32'd1);
    tick(1);  // t=40
    check("halted_cpureset", 32'(cpuReset),   32'd0);
    check("halted_state",    32'(runState),   32'd1);
    check("halted_enable",   32'(cpuEnable),  32'd0);
    check("halted_count",    32'(cycleCount), 32'd0);

    // 2-cycle glitch on switch: must not toggle
    switch = 1'b1;
    tick(2);  // t=60
    switch = 1'b0;
    tick(3);  // t=90
    check("glitch_state_a", 32'(runState), 32'd1);
    tick(3);  // t=120
    check("glitch_state_b", 32'(runState), 32'd1);

    // three single steps spaced 5 cycles
    stepRequest = 1'b1;
    tick(1);  // t=130
    check("step1_state",  32'(runState),  32'd3);
    check("step1_enable", 32'(cpuEnable), 32'd1);
    stepRequest = 1'b0;
    tick(1);  // t=140
    check("step1_after_state",  32'(runState),   32'd1);
    check("step1_after_enable", 32'(cpuEnable),  32'd0);
    check("step1_count",        32'(cycleCount), 32'd1);
    tick(3);  // t=170
    stepRequest = 1'b1;
    tick(1);  // t=180
    check("step2_enable", 32'(cpuEnable), 32'd1);
    stepRequest = 1'b0;
    tick(1);  // t=190
    check("step2_count", 32'(cycleCount), 32'd2);
    tick(3);  // t=220
    stepRequest = 1'b1;
    tick(1);  // t=230
    check("step3_enable", 32'(cpuEnable), 32'd1);
    stepRequest = 1'b0;
    tick(1);  // t=240
    check("step3_count", 32'(cycleCount), 32'd3);
    check("step3_state", 32'(runState),   32'd1);

    // switch 0->1: toggle pulse present during the 6th-7th edge window,
    // stepRequest coincides with it; toggle must win
    switch       = 1'b1;
    breakEnable  = 1'b1;
    breakAddress = 8'h20;
    pc           = 8'h1E;
    tick(6);  // t=300
    check("flip_edge6_state", 32'(runState), 32'd1);
    stepRequest = 1'b1;
    tick(1);  // t=310
    check("run_state",  32'(runState),   32'd2);
    check("run_enable", 32'(cpuEnable),  32'd1);
    check("run_count",  32'(cycleCount), 32'd3);
    stepRequest = 1'b0;
    tick(1);  // t=320
    check("run_count4", 32'(cycleCount), 32'd4);
    pc = 8'h1F;
    tick(1);  // t=330
    check("run_count5", 32'(cycleCount), 32'd5);
    pc = 8'h20;
    #1;
    check("brk_enable", 32'(cpuEnable), 32'd0);
    check("brk_state",  32'(runState),  32'd2);
    tick(1);  // t=340
    check("brk_halted_state", 32'(runState),   32'd1);
    check("brk_halted_count", 32'(cycleCount), 32'd5);

    // resume at the breakpoint PC via switch 1->0
    switch = 1'b0;
    tick(6);  // t=400
    check("resume_pre_state", 32'(runState), 32'd1);
    tick(1);  // t=410
    check("resume_state",  32'(runState),  32'd2);
    check("resume_enable", 32'(cpuEnable), 32'd1);
    pc = 8'h21;
    tick(1);  // t=420
    check("resume_count",  32'(cycleCount), 32'd6);
    check("run21_enable",  32'(cpuEnable),  32'd1);

    // CPU HALT while running
    cpuHalted = 1'b1;
    #1;
    check("cpuhalt_enable", 32'(cpuEnable), 32'd0);
    tick(1);  // t=430
    check("cpuhalt_state", 32'(runState),   32'd1);
    check("cpuhalt_count", 32'(cycleCount), 32'd6);
    cpuHalted = 1'b0;

    // run again, then abort with isReset
    switch = 1'b1;
    tick(7);  // t=500
    check("rerun_state",  32'(runState),  32'd2);
    check("rerun_enable", 32'(cpuEnable), 32'd1);
    isReset = 1'b1;
    tick(1);  // t=510
    check("abort_state",    32'(runState),   32'd0);
    check("abort_cpureset", 32'(cpuReset),   32'd1);
    check("abort_enable",   32'(cpuEnable),  32'd0);
    check("abort_count",    32'(cycleCount), 32'd0);
    isReset = 1'b0;

    // switch still high after reset: debounced into a run once halted
    tick(3);  // t=540
    check("post_rst_halted", 32'(runState), 32'd1);
    tick(3);  // t=570
    check("post_rst_wait", 32'(runState), 32'd1);
    tick(1);  // t=580
    check("post_rst_run", 32'(runState), 32'd2);

    // saturation of the 4-bit cycle counter
    tick(13); // t=710
    check("sat_13", 32'(cycleCount), 32'd13);
    tick(1);
    check("sat_14", 32'(cycleCount), 32'd14);
    tick(1);
    check("sat_15", 32'(cycleCount), 32'd15);
    tick(7);
    check("sat_hold",  32'(cycleCount), 32'd15);
    check("sat_state", 32'(runState),   32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
